// File: rtl/bus_initiator.sv
// ============================================================================
// Module   : bus_initiator
// Brief    : Single-outstanding bus initiator translating commands into
//            strobed read/write bus cycles with a one-cycle response pulse.
//            Optional write readback enabled by BUS_INITIATOR_WR_VERIFY_EN.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bus_initiator #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_wr_i,
    input  logic [ADDR_W-1:0] cmd_addr_bi,
    input  logic [DATA_W-1:0] cmd_data_bi,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_bo,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] addr_bo,
    output logic [DATA_W-1:0] data_bo,
    output logic              rd_o,
    output logic              wr_o,
    input  logic [DATA_W-1:0] data_bi,
    output logic              busy_o
);

    // Latency outside 1..4 is clamped so the 3-bit wait counter cannot wrap.
    localparam int         c_lat       = (RD_LAT < 1) ? 1 : ((RD_LAT > 4) ? 4 : RD_LAT);
    localparam logic [2:0] c_wait_init = 3'(c_lat - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
`ifdef BUS_INITIATOR_WR_VERIFY_EN
        ,
        ST_VRD   = 3'd5,
        ST_VWAIT = 3'd6
`endif
    } state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rd;
    logic              r_wr;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid_i && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        if (cmd_addr_bi[1:0] != 2'b00) begin
                            // Misaligned: answer immediately, never touch the bus.
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                        end else if (cmd_wr_i) begin
                            r_state <= ST_WRITE;
                            r_wr    <= 1'b1;
                            r_addr  <= cmd_addr_bi;
                            r_wdata <= cmd_data_bi;
                        end else begin
                            r_state <= ST_READ;
                            r_rd    <= 1'b1;
                            r_addr  <= cmd_addr_bi;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end

                ST_WRITE: begin
                    r_wr <= 1'b0;
`ifdef BUS_INITIATOR_WR_VERIFY_EN
                    r_rd    <= 1'b1;
                    r_state <= ST_VRD;
`else
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= '0;
                    r_rsp_err   <= 1'b0;
`endif
                end

                ST_READ: begin
                    r_rd    <= 1'b0;
                    r_cnt   <= c_wait_init;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= data_bi;
                        r_rsp_err   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end

`ifdef BUS_INITIATOR_WR_VERIFY_EN
                ST_VRD: begin
                    r_rd    <= 1'b0;
                    r_cnt   <= c_wait_init;
                    r_state <= ST_VWAIT;
                end

                ST_VWAIT: begin
                    if (r_cnt == 3'd0) begin
                        // r_wdata still holds the written word for the compare.
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= data_bi;
                        r_rsp_err   <= (data_bi != r_wdata);
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
`endif

                ST_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_rd        <= 1'b0;
                    r_wr        <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_bo = r_rsp_data;
    assign rsp_err_o   = r_rsp_err;
    assign addr_bo     = r_addr;
    assign data_bo     = r_wdata;
    assign rd_o        = r_rd;
    assign wr_o        = r_wr;
    assign busy_o      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 The module SHALL expose these parameters:
- ADDR_W, 13, bus address width.
- DATA_W, 32, bus data width.
- RD_LAT, 1, responder read latency in clocks; legal range 1..4.

REQ-002 The module SHALL have one clock and an asynchronous, active-low reset. Ports, in this order:
- clk  in  1  rising-edge clock
- rst_n_i  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i at a rising edge
- cmd_wr_i  in  1  1 = write, 0 = read
- cmd_addr_bi  in  ADDR_W  command address
- cmd_data_bi  in  DATA_W  write data
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_data_bo  out  DATA_W  read data or readback
- rsp_err_o  out  1  error flag, qualified by rsp_valid_o
- addr_bo  out  ADDR_W  bus address to responder
- data_bo  out  DATA_W  bus write data to responder
- rd_o  out  1  bus read strobe
- wr_o  out  1  bus write strobe
- data_bi  in  DATA_W  bus read data from responder
- busy_o  out  1  high whenever state is not IDLE

Function
REQ-003 The FSM SHALL have the states IDLE, WRITE, READ, WAIT, RESP, VRD and VWAIT; VRD and VWAIT are present only when the verify macro is defined.
REQ-004 cmd_ready_o SHALL be registered and high only in IDLE; a command SHALL be accepted at edge E0 when cmd_valid_i and cmd_ready_o are both high, with all command fields captured at E0.
REQ-005 A command with cmd_addr_bi[1:0] != 0 SHALL be rejected: IDLE->RESP, no rd_o or wr_o, rsp_err_o=1, rsp_data_bo=0.
REQ-006 Write path: IDLE->WRITE. In the cycle after E0, wr_o=1 for exactly one cycle with addr_bo and data_bo driven from the captured command. Next state is RESP.
REQ-007 Read path: IDLE->READ. In the cycle after E0, rd_o=1 for exactly one cycle with addr_bo driven. The FSM then holds WAIT for RD_LAT cycles using a 3-bit down-counter. data_bi SHALL be sampled at the edge ending the last WAIT cycle, then the FSM moves to RESP.
REQ-008 RESP SHALL last exactly one cycle with rsp_valid_o=1, then return to IDLE. rsp_valid_o has no backpressure.
REQ-009 Latency at RD_LAT=1: write gives wr_o in cycle 1 and rsp_valid_o in cycle 2; read gives rd_o in cycle 1 and rsp_valid_o in cycle 3; cmd_ready_o is high again in the cycle after RESP.
REQ-010 rd_o and wr_o SHALL never be high in the same cycle.
REQ-011 addr_bo and data_bo SHALL hold their last driven values outside strobe cycles.
REQ-012 rsp_data_bo and rsp_err_o SHALL hold until the next RESP.
REQ-013 Commands presented while cmd_ready_o=0 SHALL be ignored and not queued.

Reset
REQ-014 While rst_n_i=0, all outputs SHALL be 0 and the state SHALL be IDLE, applied asynchronously; this includes cmd_ready_o=0, rd_o=0 and wr_o=0.
REQ-015 cmd_ready_o SHALL go to 1 at the first rising edge after rst_n_i deasserts.
REQ-016 Asserting reset mid-transaction SHALL discard the transaction and produce no response.

Configuration
REQ-017 Macro BUS_INITIATOR_WR_VERIFY_EN controls write readback:
- Defined: WRITE is followed by VRD (rd_o=1 for one cycle to the same address), then VWAIT for RD_LAT cycles, then data_bi is sampled and the FSM moves to RESP with rsp_data_bo = readback and rsp_err_o = (readback != written data).
- Undefined: writes respond with rsp_data_bo=0 and rsp_err_o=0, and VRD/VWAIT are not synthesized.

Verification
REQ-018 After reset release, a write to 8 with data 0x2 -> wr_o=1 with addr_bo=8 and data_bo=0x2 for one cycle after accept; rsp_valid_o=1 and rsp_err_o=0 in the next cycle.
REQ-019 With a responder model returning 0x1234 at RD_LAT=1, a read of address 0 -> rd_o for one cycle, then rsp_valid_o two cycles later with rsp_data_bo=0x1234.
REQ-020 A read of address 6 -> no rd_o or wr_o; rsp_valid_o=1 and rsp_err_o=1 in the cycle after accept.
REQ-021 Reset asserted during WAIT -> rd_o, wr_o, rsp_valid_o and cmd_ready_o are 0 immediately and no response follows; cmd_ready_o=1 at the first edge after release.
REQ-022 cmd_valid_i held high over two reads -> the second read is accepted only after the first RESP, and rd_o and wr_o are never high together.
REQ-023 With BUS_INITIATOR_WR_VERIFY_EN defined, writing 0x5 to address 4 against a model that returns 0x6 -> one wr_o, one rd_o, then rsp_err_o=1 and rsp_data_bo=0x6.
